// File: rtl/onchip_mem_arb_pkg.sv
// onchip_mem_arb_pkg: shared widths, owner tags and arbiter state encoding
package onchip_mem_arb_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 256;
    localparam int BE_W   = DATA_W / 8;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_A    = 2'd1;
    localparam logic [1:0] OWN_B    = 2'd2;
    typedef enum logic {ARB_A, ARB_B} arb_state_t;
endpackage

// File: rtl/onchip_mem_arb_if.sv
// onchip_mem_arb_if: single-port pattern memory command/read-data bus
//  master (arbiter): drives mem_cs/mem_rd/mem_wr/mem_addr/mem_be/mem_wdata, samples mem_rdata
//  slave  (memory) : samples the command, drives mem_rdata
interface onchip_mem_arb_if;
    import onchip_mem_arb_pkg::*;
    logic              mem_cs;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport master (output mem_cs, mem_rd, mem_wr, mem_addr, mem_be, mem_wdata, input mem_rdata);
    modport slave  (input mem_cs, mem_rd, mem_wr, mem_addr, mem_be, mem_wdata, output mem_rdata);
endinterface

// File: rtl/onchip_mem_arb_tag_pipe.sv
// arb_tag_pipe: DEPTH-stage shift register carrying the read owner tag alongside memory latency
//  clk, rst_n (async active-low) ; tag_in: tag of the command now on the bus ; tag_out: owner of read data now valid
module arb_tag_pipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out
);
    logic [1:0] pipe [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= OWN_NONE;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/onchip_mem_arb.sv
// onchip_mem_arb: two-requester arbiter for the single-port on-chip pattern memory
//  clk, rst_n (async active-low)
//  a_req/a_addr -> a_gnt (comb), a_rvalid : high-priority read-only pixel fetch port
//  b_req/b_we/b_addr/b_wdata/b_be -> b_gnt (comb), b_rvalid : low-priority loader port
//  rdata : memory read data passthrough, qualified by a_rvalid/b_rvalid
//  mem   : registered memory command bus (onchip_mem_arb_if.master)
//  ONCHIP_MEM_ARB_STATS_EN adds saturating a_gnt_cnt, b_gnt_cnt, b_wait_cnt outputs
module onchip_mem_arb
    import onchip_mem_arb_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int A_MAX_RUN  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [BE_W-1:0]   b_be,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
`ifdef ONCHIP_MEM_ARB_STATS_EN
    onchip_mem_arb_if.master  mem,
    output logic [31:0]       a_gnt_cnt,
    output logic [31:0]       b_gnt_cnt,
    output logic [31:0]       b_wait_cnt
`else
    onchip_mem_arb_if.master  mem
`endif
);
    localparam logic [7:0] RUN_LAST = 8'(A_MAX_RUN - 1);
    arb_state_t state;
    logic [7:0] run_cnt;
    logic [1:0] cmd_tag;
    logic [1:0] rsp_tag;
    // In ARB_B a pending B wins outright; otherwise A wins whenever it asks.
    always_comb begin
        a_gnt    = rst_n & a_req & (state == ARB_A | ~b_req);
        b_gnt    = rst_n & b_req & ~a_gnt;
        a_rvalid = rsp_tag == OWN_A;
        b_rvalid = rsp_tag == OWN_B;
        rdata    = mem.mem_rdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB_A;
            run_cnt       <= '0;
            cmd_tag       <= OWN_NONE;
            mem.mem_cs    <= 1'b0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            mem.mem_cs <= a_gnt | b_gnt;
            mem.mem_rd <= a_gnt | (b_gnt & ~b_we);
            mem.mem_wr <= b_gnt & b_we;
            cmd_tag    <= a_gnt ? OWN_A : (b_gnt & ~b_we) ? OWN_B : OWN_NONE;
            if (a_gnt) begin
                mem.mem_addr <= a_addr;
                mem.mem_be   <= '1;
            end
            if (b_gnt) begin
                mem.mem_addr  <= b_addr;
                mem.mem_be    <= b_be;
                mem.mem_wdata <= b_wdata;
            end
            // Counts A grants that B has had to sit through; any B service or idle B clears it.
            run_cnt <= (a_gnt & b_req) ? (run_cnt == RUN_LAST ? run_cnt : run_cnt + 8'd1) : 8'd0;
            state   <= (state == ARB_A & a_gnt & b_req & run_cnt == RUN_LAST) ? ARB_B : ARB_A;
        end
    end
    arb_tag_pipe #(.DEPTH(MEM_RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (cmd_tag),
        .tag_out (rsp_tag)
    );
`ifdef ONCHIP_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gnt_cnt  <= '0;
            b_gnt_cnt  <= '0;
            b_wait_cnt <= '0;
        end else begin
            if (a_gnt && a_gnt_cnt != '1) a_gnt_cnt <= a_gnt_cnt + 32'd1;
            if (b_gnt && b_gnt_cnt != '1) b_gnt_cnt <= b_gnt_cnt + 32'd1;
            if (b_req && !b_gnt && b_wait_cnt != '1) b_wait_cnt <= b_wait_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_onchip_mem_arb.sv
// tb_onchip_mem_arb: directed + randomized bench with a behavioural arbiter/memory model
module tb_onchip_mem_arb;
    localparam int A_MAX_RUN = 8;
    localparam int LAT = 1;
    logic clk = 0;
    logic rst_n = 0;
    logic a_req = 0, b_req = 0, b_we = 0;
    logic [10:0] a_addr = 0, b_addr = 0;
    logic [255:0] b_wdata = 0;
    logic [31:0] b_be = 0;
    logic a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [255:0] rdata;
`ifdef ONCHIP_MEM_ARB_STATS_EN
    logic [31:0] a_gnt_cnt, b_gnt_cnt, b_wait_cnt;
`endif
    onchip_mem_arb_if mem_bus ();
    onchip_mem_arb #(.MEM_RD_LAT(LAT), .A_MAX_RUN(A_MAX_RUN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .rdata(rdata),
`ifdef ONCHIP_MEM_ARB_STATS_EN
        .mem(mem_bus), .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt), .b_wait_cnt(b_wait_cnt)
`else
        .mem(mem_bus)
`endif
    );
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory device: registered read, one cycle latency, byte-enabled write.
    logic [255:0] mem [0:2047];
    always @(posedge clk) begin
        if (mem_bus.mem_cs && mem_bus.mem_wr)
            for (int i = 0; i < 32; i++)
                if (mem_bus.mem_be[i]) mem[mem_bus.mem_addr][i*8 +: 8] <= mem_bus.mem_wdata[i*8 +: 8];
        if (mem_bus.mem_cs && mem_bus.mem_rd) mem_bus.mem_rdata <= mem[mem_bus.mem_addr];
    end

    // Reference model state: shadow contents at grant time, outstanding responses, B starvation streak.
    typedef struct { int due; logic own_a; logic [255:0] data; } resp_t;
    resp_t rq[$];
    logic [255:0] sh [0:2047];
    int ncyc = 0, streak = 0, m_a = 0, m_b = 0, m_w = 0;
    logic e_cs = 0, e_rd = 0, e_wr = 0;
    logic [10:0] e_addr = 0;
    logic [31:0] e_be = 0;
    logic [255:0] e_wd = 0;
    logic ga = 0, gb = 0;
    byte g_log[$];
    logic [255:0] a_log[$], b_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", {a_gnt, b_gnt}, 0);
            chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
            chk("rst_strobes", {mem_bus.mem_cs, mem_bus.mem_rd, mem_bus.mem_wr}, 0);
            chk("rst_addr", mem_bus.mem_addr, 0);
            chk("rst_be", mem_bus.mem_be, 0);
            chk("rst_wdata", mem_bus.mem_wdata, 0);
            rq.delete();
            streak = 0; m_a = 0; m_b = 0; m_w = 0;
            e_cs = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_be = 0; e_wd = 0;
            ga = 0; gb = 0;
        end else begin
            logic ea, eb, hit;
            ncyc++;
            ea = a_req && !(b_req && streak >= A_MAX_RUN);
            eb = b_req && !ea;
            chk("a_gnt", a_gnt, ea);
            chk("b_gnt", b_gnt, eb);
            chk("one_grant", a_gnt & b_gnt, 0);
            chk("mem_strobes", {mem_bus.mem_cs, mem_bus.mem_rd, mem_bus.mem_wr}, {e_cs, e_rd, e_wr});
            chk("mem_addr", mem_bus.mem_addr, e_addr);
            if (e_wr) begin
                chk("mem_be", mem_bus.mem_be, e_be);
                chk("mem_wdata", mem_bus.mem_wdata, e_wd);
            end
            hit = rq.size() > 0 && rq[0].due == ncyc;
            chk("a_rvalid", a_rvalid, hit && rq[0].own_a);
            chk("b_rvalid", b_rvalid, hit && !rq[0].own_a);
            if (hit) begin
                chk("rdata", rdata, rq[0].data);
                void'(rq.pop_front());
            end
`ifdef ONCHIP_MEM_ARB_STATS_EN
            chk("a_gnt_cnt", a_gnt_cnt, m_a);
            chk("b_gnt_cnt", b_gnt_cnt, m_b);
            chk("b_wait_cnt", b_wait_cnt, m_w);
`endif
            if (a_gnt) g_log.push_back("A");
            if (b_gnt) g_log.push_back("B");
            if (a_rvalid) a_log.push_back(rdata);
            if (b_rvalid) b_log.push_back(rdata);
            ga = a_gnt; gb = b_gnt;
            e_cs = ea || eb;
            e_rd = ea || (eb && !b_we);
            e_wr = eb && b_we;
            if (ea) begin
                e_addr = a_addr;
                rq.push_back('{ncyc + 1 + LAT, 1'b1, sh[a_addr]});
            end
            if (eb) begin
                e_addr = b_addr;
                if (b_we) begin
                    e_be = b_be; e_wd = b_wdata;
                    for (int i = 0; i < 32; i++) if (b_be[i]) sh[b_addr][i*8 +: 8] = b_wdata[i*8 +: 8];
                end else rq.push_back('{ncyc + 1 + LAT, 1'b0, sh[b_addr]});
            end
            streak = (ea && b_req) ? streak + 1 : 0;
            m_a += int'(ea); m_b += int'(eb); m_w += int'(b_req && !eb);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b();
        int k = 0;
        @(negedge clk);
        while (!b_gnt && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("b_gnt_wait", b_gnt, 1);
    endtask

    function automatic void clear_logs();
        g_log.delete(); a_log.delete(); b_log.delete();
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp1 [4];
        exp1[0] = {32{8'h10}}; exp1[1] = {32{8'h11}}; exp1[2] = {32{8'h12}}; exp1[3] = {32{8'h13}};
        for (int i = 0; i < 2048; i++) begin
            mem[i] = (i < 16) ? {32{8'(8'h10 + i)}} : '0;
            sh[i] = mem[i];
        end
        mem_bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
`ifdef ONCHIP_MEM_ARB_STATS_EN
        cyc();
        a_req = 1; b_req = 1; b_we = 0; b_addr = 3;
        repeat (4) cyc();
        cyc(); a_req = 0;
        repeat (2) cyc();
        cyc(); b_req = 0; a_req = 1;
        repeat (4) cyc();
        cyc(); a_req = 0;
        cyc();
        @(negedge clk);
        chk("stats_a", a_gnt_cnt, 10);
        chk("stats_b", b_gnt_cnt, 3);
        chk("stats_wait", b_wait_cnt, 5);
`endif
        cyc(); clear_logs();
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_addr = 11'(i);
            cyc();
        end
        a_req = 0;
        repeat (4) cyc();
        chk("t1_grants", g_log.size(), 4);
        chk("t1_reads", a_log.size(), 4);
        for (int i = 0; i < 4 && i < a_log.size(); i++) chk("t1_rdata", a_log[i], exp1[i]);
        chk("t1_no_b", b_log.size(), 0);

        clear_logs();
        b_req = 1; b_we = 1; b_addr = 5; b_wdata = 256'h77; b_be = '1;
        wait_b();
        cyc(); b_we = 0;
        wait_b();
        cyc(); b_req = 0;
        repeat (4) cyc();
        chk("t2_b_reads", b_log.size(), 1);
        if (b_log.size() > 0) chk("t2_rdata", b_log[0][7:0], 8'h77);

        clear_logs();
        a_req = 1; a_addr = 0; b_req = 1; b_we = 0; b_addr = 1;
        repeat (27) cyc();
        a_req = 0; b_req = 0;
        chk("t3_grants", g_log.size(), 27);
        for (int k = 0; k < 27 && k < g_log.size(); k++) chk("t3_pattern", g_log[k], (k % 9 == 8) ? "B" : "A");

        cyc(); clear_logs();
        a_req = 1; b_req = 1; b_addr = 2;
        repeat (3) cyc();
        a_req = 0;
        cyc(); b_req = 0;
        repeat (3) cyc();
        chk("t4_grants", g_log.size(), 4);
        if (g_log.size() == 4) chk("t4_order", {g_log[0], g_log[1], g_log[2], g_log[3]}, "AAAB");

        clear_logs();
        a_req = 1; a_addr = 2;
        cyc(); a_req = 0; rst_n = 0;
        cyc(); rst_n = 1;
        @(negedge clk);
        chk("t5_mem_idle", {mem_bus.mem_cs, mem_bus.mem_rd, mem_bus.mem_wr}, 0);
        chk("t5_mem_addr", mem_bus.mem_addr, 0);
        repeat (4) cyc();
        chk("t5_no_rvalid", a_log.size(), 0);

        repeat (3000) begin
            cyc();
            if (!a_req || ga) begin
                a_req = $urandom_range(0, 3) != 0;
                a_addr = 11'($urandom_range(0, 15));
            end else if ($urandom_range(0, 19) == 0) a_req = 0;
            if (!b_req || gb) begin
                b_req = $urandom_range(0, 2) != 0;
                b_we = 1'($urandom_range(0, 1));
                b_addr = 11'($urandom_range(0, 15));
                for (int i = 0; i < 8; i++) b_wdata[i*32 +: 32] = $urandom;
                b_be = $urandom;
            end else if ($urandom_range(0, 19) == 0) b_req = 0;
        end
        cyc(); a_req = 0; b_req = 0;
        repeat (5) cyc();
        chk("drain", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
